// File: rtl/switch_bounce_emulator_pkg.sv
// Shared types and constants for the switch bounce emulator.
package sw_emu_pkg;

  typedef enum logic [1:0] {
    S_LOW         = 2'd0,
    S_BOUNCE_RISE = 2'd1,
    S_HIGH        = 2'd2,
    S_BOUNCE_FALL = 2'd3
  } sw_emu_state_t;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  // Right-shifting Galois step; feedback enters at the tap mask when bit 0 falls out.
  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
  endfunction

endpackage

// File: rtl/switch_bounce_emulator_lfsr.sv
// 16-bit Galois LFSR driving the bounce segment lengths.
// A zero seed would lock the register at zero, so it is replaced by 16'h0001.
module sw_emu_lfsr
  import sw_emu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= (seed == 16'h0000) ? 16'h0001 : seed;
    else     q <= lfsr_next(q);
  end

endmodule

// File: rtl/switch_bounce_emulator.sv
// Mechanical switch emulator: turns a clean request level into a pseudo-random
// glitch burst of BOUNCE_WINDOW cycles followed by a stable level. Optional
// transition counter output glitch_cnt is enabled by `define SW_EMU_STATS_EN.
//
//   state         | meaning
//   S_LOW         | stable low, waiting for press_req=1
//   S_BOUNCE_RISE | bouncing, settles high
//   S_HIGH        | stable high, waiting for press_req=0
//   S_BOUNCE_FALL | bouncing, settles low
module switch_bounce_emulator
  import sw_emu_pkg::*;
#(
  parameter int          BOUNCE_WINDOW = 500000,
  parameter int          GLITCH_W      = 12,
  parameter logic [15:0] LFSR_SEED     = LFSR_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        press_req,
  output logic        sw_out,
  output logic        busy,
  output logic        settled
`ifdef SW_EMU_STATS_EN
  ,
  output logic [15:0] glitch_cnt
`endif
);

  localparam int WIN_W = $clog2(BOUNCE_WINDOW);

  sw_emu_state_t       state_q, state_d;
  logic                sw_d, busy_d, settled_d;
  logic [WIN_W-1:0]    win_q, win_d;
  logic [GLITCH_W-1:0] seg_q, seg_d;
  logic [15:0]         lfsr_q;
  logic                final_lvl;
  logic                unused_lfsr_bits;

  sw_emu_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  assign unused_lfsr_bits = ^lfsr_q;
  assign final_lvl        = (state_q == S_BOUNCE_RISE);

  always_comb begin
    state_d   = state_q;
    sw_d      = sw_out;
    busy_d    = busy;
    settled_d = 1'b0;
    win_d     = win_q;
    seg_d     = seg_q;
    case (state_q)
      S_LOW, S_HIGH: begin
        // Entry drives the new level immediately: the early edge of the burst.
        if (press_req != (state_q == S_HIGH)) begin
          state_d = (state_q == S_LOW) ? S_BOUNCE_RISE : S_BOUNCE_FALL;
          sw_d    = press_req;
          busy_d  = 1'b1;
          win_d   = WIN_W'(BOUNCE_WINDOW - 1);
          seg_d   = lfsr_q[GLITCH_W-1:0];
        end
      end
      default: begin
        // Window expiry has priority over a coinciding segment expiry.
        if (win_q == '0) begin
          state_d   = final_lvl ? S_HIGH : S_LOW;
          sw_d      = final_lvl;
          busy_d    = 1'b0;
          settled_d = 1'b1;
        end else begin
          win_d = win_q - WIN_W'(1);
          if (seg_q == '0) begin
            sw_d  = ~sw_out;
            seg_d = lfsr_q[GLITCH_W-1:0];
          end else begin
            seg_d = seg_q - GLITCH_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOW;
      sw_out  <= 1'b0;
      busy    <= 1'b0;
      settled <= 1'b0;
      win_q   <= '0;
      seg_q   <= '0;
    end else begin
      state_q <= state_d;
      sw_out  <= sw_d;
      busy    <= busy_d;
      settled <= settled_d;
      win_q   <= win_d;
      seg_q   <= seg_d;
    end
  end

`ifdef SW_EMU_STATS_EN
  logic [15:0] gc_d;
  logic        bouncing;

  assign bouncing = (state_q == S_BOUNCE_RISE) || (state_q == S_BOUNCE_FALL);

  always_comb begin
    gc_d = glitch_cnt;
    if (!bouncing && (state_d != state_q))
      gc_d = 16'd1;
    else if (bouncing && (sw_d != sw_out) && (glitch_cnt != 16'hFFFF))
      gc_d = glitch_cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) glitch_cnt <= 16'd0;
    else     glitch_cnt <= gc_d;
  end
`endif

endmodule

// File: doc/switch_bounce_emulator.md
Name: switch_bounce_emulator

Overview:
- Synthesizable mechanical-switch emulator: the driving end of the switch/debounce interface.
- Converts a clean requested switch level into a realistic bouncy `sw_out` waveform: a pseudo-random glitch burst of fixed length, then a stable level.
- Used on-board and in benches to exercise debounce logic and the ROM adder input path deterministically.

Parameters:
- `BOUNCE_WINDOW`, default 500000: cycles spent bouncing per edge (5 ms at 100 MHz); must be ≥ 2.
- `GLITCH_W`, default 12: width of the LFSR slice setting segment length; segment length is 1 to 2^GLITCH_W cycles.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; 0 is replaced by 16'h0001.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `press_req` input 1: requested clean switch level (1 = pressed).
- `sw_out` output 1: emulated bouncy switch line.
- `busy` output 1: high while in a bounce state.
- `settled` output 1: one-cycle pulse when `sw_out` reaches its stable level after a bounce.

Behaviour:
- Reset (`rst`=1 at a clk edge):
  - State goes to `S_LOW`.
  - `sw_out`=0, `busy`=0, `settled`=0.
  - LFSR is loaded with the seed; window and segment counters are cleared.
  - Reset mid-bounce aborts immediately; the output is low on the next cycle.
- All outputs are registered.
- LFSR:
  - 16-bit Galois, tap mask 16'hB400.
  - Advances every cycle when not in reset.
  - Segment length = `lfsr[GLITCH_W-1:0]` + 1, sampled at each segment load.
- FSM states: `S_LOW`, `S_BOUNCE_RISE`, `S_HIGH`, `S_BOUNCE_FALL`.
- `S_LOW`: `sw_out`=0. If `press_req`=1 is sampled at edge t, then at t+1:
  - state = `S_BOUNCE_RISE`, `sw_out`=1 (early edge), `busy`=1;
  - window counter = `BOUNCE_WINDOW`-1;
  - segment counter loaded.
- `S_BOUNCE_RISE`:
  - Window counter decrements every cycle.
  - Segment counter decrements; at 0, `sw_out` toggles and the segment reloads.
  - When the window counter reaches 0, then on the next cycle: state = `S_HIGH`, `sw_out`=1 forced, `busy`=0, `settled`=1 for exactly one cycle.
  - If segment expiry and window expiry coincide, the window wins: no toggle, forced final level.
  - Total bounce time is exactly `BOUNCE_WINDOW` cycles (t+1 .. t+`BOUNCE_WINDOW`); the stable level appears at t+`BOUNCE_WINDOW`+1.
- `S_HIGH`: `sw_out`=1. `press_req`=0 starts `S_BOUNCE_FALL`, mirroring the rise with `sw_out`=0 on entry and final level 0, then returns to `S_LOW` with a `settled` pulse.
- `press_req` changes during a bounce are ignored. After settling, a request level that differs from `sw_out` starts the opposite bounce on the next edge (no idle gap beyond one cycle).
- `press_req` is assumed synchronous to `clk`; no internal synchronizer.

Optional Feature:
- Macro: `SW_EMU_STATS_EN`.
- Defined:
  - Adds output port `glitch_cnt` [15:0]: number of `sw_out` transitions in the current/last bounce, including the entry edge and the final forced edge if it changes level.
  - Cleared on bounce entry (entry edge counts as 1); saturates at 16'hFFFF; holds after settling; reset to 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package `sw_emu_pkg`:
  - state enum `sw_emu_state_t` (2-bit);
  - `LFSR_TAPS` = 16'hB400;
  - `LFSR_SEED_DEFAULT` = 16'hACE1.
- Sub-module `sw_emu_lfsr` (16-bit Galois LFSR; ports `clk`, `rst`, `seed`, `q`). Zero-seed substitution happens inside it.
- Counters and FSM live in the top module.

Test Plan:
- Reset: hold `rst`=1 for 3 cycles with `press_req`=1 → `sw_out`=0, `busy`=0, `settled`=0 throughout; first bounce starts the cycle after `rst` drops.
- Press, with `BOUNCE_WINDOW`=64, `GLITCH_W`=3: `press_req` 0→1 sampled at t → `sw_out`=1 and `busy`=1 at t+1; ≥1 toggle within t+1..t+64; at t+65 `sw_out`=1, `settled`=1 for one cycle, `busy`=0; stable thereafter.
- Release with same parameters: `press_req` 1→0 at t → `sw_out`=0 at t+1; `sw_out`=0 stable from t+65 with a `settled` pulse at t+65.
- Short request: `press_req`=1 for 10 cycles then 0 → full 64-cycle rise bounce completes to `S_HIGH`, fall bounce begins the next cycle, final `sw_out`=0.
- Segment bounds, with `GLITCH_W`=3, 20 presses: every inter-toggle interval inside a bounce is 1..8 cycles; no toggle after the `settled` pulse.
- Determinism: reset mid-bounce (cycle 30 of 64) → `sw_out`=0 next cycle; replay the identical `press_req` sequence → bit-identical `sw_out` trace; with `SW_EMU_STATS_EN`, `glitch_cnt` equals the counted transitions.
